wash_control: RTL

WASH_CONTROL -- requirements
Module: wash_control

---
 rtl/wash_control.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/wash_control.sv
// wash_control: washing-machine program sequencer.
// A program selects a subset of the WASH / RINSE / DRY stages. Each stage is a
// fixed chain of timed sub-phases, and `data` counts down the remaining seconds.
// Sub-phases are numbered globally 0..7 in LED order:
//   w_in, w_W, r_out, r_spin, r_in, r_R, d_out, d_spin.
// Every output is driven directly from a flop.
module wash_control #(
    parameter int T_IN    = 3,
    parameter int T_OUT   = 3,
    parameter int T_SPIN  = 3,
    parameter int T_WASH  = 9,
    parameter int T_RINSE = 6,
    parameter int T_DRY   = 6
) (
    input  logic       cp,
    input  logic       nCR,
    input  logic       tick,
    input  logic       power_key,
    input  logic       start_key,
    input  logic       mode_key,
    output logic [2:0] state,
    output logic [8:0] data,
    output logic       w_inWaterLED,
    output logic       w_WLED,
    output logic       r_outWaterLED,
    output logic       r_spinWaterLED,
    output logic       r_inWaterLED,
    output logic       r_RLED,
    output logic       d_outWaterLED,
    output logic       d_spinWaterLED,
    output logic       setLED,
    output logic       powerLED
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_SET   = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_DRY   = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [8:0] LEN_W = 9'(T_IN + T_WASH);
    localparam logic [8:0] LEN_R = 9'(T_OUT + T_SPIN + T_IN + T_RINSE);
    localparam logic [8:0] LEN_D = 9'(T_OUT + T_DRY);

    // Length in ticks of a sub-phase.
    function automatic logic [8:0] sub_len(input logic [2:0] sp);
        case (sp)
            3'd0:    sub_len = 9'(T_IN);
            3'd1:    sub_len = 9'(T_WASH);
            3'd2:    sub_len = 9'(T_OUT);
            3'd3:    sub_len = 9'(T_SPIN);
            3'd4:    sub_len = 9'(T_IN);
            3'd5:    sub_len = 9'(T_RINSE);
            3'd6:    sub_len = 9'(T_OUT);
            3'd7:    sub_len = 9'(T_DRY);
            default: sub_len = 9'd0;
        endcase
    endfunction

    // Stage that owns a sub-phase.
    function automatic state_t stage_of(input logic [2:0] sp);
        case (sp)
            3'd0, 3'd1:             stage_of = S_WASH;
            3'd2, 3'd3, 3'd4, 3'd5: stage_of = S_RINSE;
            default:                stage_of = S_DRY;
        endcase
    endfunction

    // Selected stages of a program: bit0 WASH, bit1 RINSE, bit2 DRY.
    function automatic logic [2:0] stage_mask(input logic [2:0] prog);
        case (prog)
            3'd0:    stage_mask = 3'b111;
            3'd1:    stage_mask = 3'b001;
            3'd2:    stage_mask = 3'b011;
            3'd3:    stage_mask = 3'b110;
            3'd4:    stage_mask = 3'b010;
            3'd5:    stage_mask = 3'b100;
            default: stage_mask = 3'b000;
        endcase
    endfunction

    // Total program duration in ticks.
    function automatic logic [8:0] prog_total(input logic [2:0] prog);
        logic [2:0] m;
        m = stage_mask(prog);
        prog_total = (m[0] ? LEN_W : 9'd0) + (m[1] ? LEN_R : 9'd0) + (m[2] ? LEN_D : 9'd0);
    endfunction

    // First sub-phase of the first selected stage.
    function automatic logic [2:0] first_sub(input logic [2:0] prog);
        logic [2:0] m;
        m = stage_mask(prog);
        if (m[0]) begin
            first_sub = 3'd0;
        end else if (m[1]) begin
            first_sub = 3'd2;
        end else begin
            first_sub = 3'd6;
        end
    endfunction

    // Successor sub-phase; MSB set means the program has ended.
    function automatic logic [3:0] next_sub(input logic [2:0] sp, input logic [2:0] m);
        case (sp)
            3'd1: begin
                if (m[1]) begin
                    next_sub = {1'b0, 3'd2};
                end else if (m[2]) begin
                    next_sub = {1'b0, 3'd6};
                end else begin
                    next_sub = {1'b1, 3'd0};
                end
            end
            3'd5: begin
                if (m[2]) begin
                    next_sub = {1'b0, 3'd6};
                end else begin
                    next_sub = {1'b1, 3'd0};
                end
            end
            3'd7:    next_sub = {1'b1, 3'd0};
            default: next_sub = {1'b0, 3'(sp + 3'd1)};
        endcase
    endfunction

    state_t     state_q, state_d;
    state_t     saved_q, saved_d;
    logic [2:0] prog_q, prog_d;
    logic [8:0] data_q, data_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] sub_q, sub_d;
    logic [7:0] led_q, led_d;
    logic       set_led_q, set_led_d;
    logic       pwr_led_q, pwr_led_d;
    logic [3:0] nxt_s;
    logic [2:0] fs_s;

    // Next-state and next-output computation with power > start > tick > mode priority.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        prog_d  = prog_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        nxt_s   = next_sub(sub_q, stage_mask(prog_q));
        fs_s    = first_sub(prog_q);
        if (power_key) begin
            if (state_q == S_OFF) begin
                state_d = S_SET;
                prog_d  = 3'd0;
                data_d  = prog_total(3'd0);
                cnt_d   = 9'd0;
                sub_d   = 3'd0;
                saved_d = S_OFF;
            end else begin
                state_d = S_OFF;
                prog_d  = 3'd0;
                data_d  = 9'd0;
                cnt_d   = 9'd0;
                sub_d   = 3'd0;
                saved_d = S_OFF;
            end
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_OFF;
                end
                S_SET: begin
                    if (start_key) begin
                        sub_d   = fs_s;
                        cnt_d   = sub_len(fs_s);
                        state_d = stage_of(fs_s);
                    end else if (mode_key) begin
                        prog_d = (prog_q == 3'd5) ? 3'd0 : 3'(prog_q + 3'd1);
                        data_d = prog_total(prog_d);
                    end else begin
                        state_d = S_SET;
                    end
                end
                S_WASH, S_RINSE, S_DRY: begin
                    if (start_key) begin
                        saved_d = state_q;
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        data_d = data_q - 9'd1;
                        if (cnt_q == 9'd1) begin
                            if (nxt_s[3]) begin
                                state_d = S_DONE;
                                data_d  = 9'd0;
                                cnt_d   = 9'd0;
                                sub_d   = 3'd0;
                            end else begin
                                sub_d   = nxt_s[2:0];
                                cnt_d   = sub_len(nxt_s[2:0]);
                                state_d = stage_of(nxt_s[2:0]);
                            end
                        end else begin
                            cnt_d = cnt_q - 9'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                S_PAUSE: begin
                    if (start_key) begin
                        state_d = saved_q;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                S_DONE: begin
                    if (start_key) begin
                        state_d = S_SET;
                        data_d  = prog_total(prog_q);
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_OFF;
                    data_d  = 9'd0;
                    cnt_d   = 9'd0;
                    sub_d   = 3'd0;
                    prog_d  = 3'd0;
                end
            endcase
        end
        if ((state_d == S_WASH) || (state_d == S_RINSE) || (state_d == S_DRY) || (state_d == S_PAUSE)) begin
            led_d = 8'd1 << sub_d;
        end else begin
            led_d = 8'd0;
        end
        set_led_d = (state_d == S_SET);
        pwr_led_d = (state_d != S_OFF);
    end

    // State and output registers, cleared asynchronously by nCR.
    always_ff @(posedge cp or negedge nCR) begin
        if (!nCR) begin
            state_q   <= S_OFF;
            saved_q   <= S_OFF;
            prog_q    <= 3'd0;
            data_q    <= 9'd0;
            cnt_q     <= 9'd0;
            sub_q     <= 3'd0;
            led_q     <= 8'd0;
            set_led_q <= 1'b0;
            pwr_led_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            prog_q    <= prog_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            led_q     <= led_d;
            set_led_q <= set_led_d;
            pwr_led_q <= pwr_led_d;
        end
    end

    assign state          = state_q;
    assign data           = data_q;
    assign w_inWaterLED   = led_q[0];
    assign w_WLED         = led_q[1];
    assign r_outWaterLED  = led_q[2];
    assign r_spinWaterLED = led_q[3];
    assign r_inWaterLED   = led_q[4];
    assign r_RLED         = led_q[5];
    assign d_outWaterLED  = led_q[6];
    assign d_spinWaterLED = led_q[7];
    assign setLED         = set_led_q;
    assign powerLED       = pwr_led_q;

endmodule
